// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package cpu_fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF   = 32'h0000_0000;
    localparam logic [5:0]         HALT_OPCODE_DEF = 6'h3F;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // True when the word's opcode field matches the halt opcode
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                     input logic [5:0]         halt_op);
        return instr[OPCODE_MSB:OPCODE_LSB] == halt_op;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush, invalidate and hold
module if_id_reg
    import cpu_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [31:0]        PC_MASK   = 32'h0000_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               invalidate_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus1_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_plus1_q;
    logic               valid_q;

    // Flush beats load beats invalidate; with no control asserted everything holds.
    // Flush only bubbles the word and valid; the pc fields keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus1_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus1_q <= (pc_i + 32'd1) & PC_MASK;
            valid_q    <= 1'b1;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage owning the PC, fetch FSM and delivery counter
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0]        RESET_PC    = 32'h0000_0000,
    parameter int                 PC_BITS     = 16,
    parameter logic [5:0]         HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    localparam logic [31:0] PC_MASK = (PC_BITS >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << PC_BITS) - 32'd1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q, halted_d;
    logic [31:0]  count_q, count_d;
    logic         load, flush, invalidate;

    // State, PC, halt flag and delivery counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC & PC_MASK;
            halted_q <= 1'b0;
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    // Next-state: redirect wins over everything outside BOOT, then stall, then advance
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = halted_q;
        count_d    = count_q;
        load       = 1'b0;
        flush      = 1'b0;
        invalidate = 1'b0;
        if (state_q != BOOT && redirect) begin
            pc_d     = redirect_pc & PC_MASK;
            flush    = 1'b1;
            halted_d = 1'b0;
            state_d  = FETCH;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (!stall) begin
                        load    = 1'b1;
                        count_d = count_q + 32'd1;
                        pc_d    = (pc_q + 32'd1) & PC_MASK;
                        if (is_halt(imem_instr, HALT_OPCODE)) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
                HALT: begin
                    // Halt word stays visible until decode takes it
                    if (!stall) begin
                        invalidate = 1'b1;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR),
        .PC_MASK   (PC_MASK)
    ) u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .flush_i      (flush),
        .invalidate_i (invalidate),
        .instr_i      (imem_instr),
        .pc_i         (pc_q),
        .instr_o      (if_id_instr),
        .pc_o         (if_id_pc),
        .pc_plus1_o   (if_id_pc_plus1),
        .valid_o      (if_id_valid)
    );

    assign imem_addr   = pc_q & PC_MASK;
    assign imem_rd_en  = (state_q == FETCH) && !stall;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus1;
    } cap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:65535];
    cap_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_count = 32'h0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory model: word read during the low phase
    always @(negedge clk) imem_instr = mem[imem_addr[15:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pp1);
        cap_t c;
        c.instr = instr; c.pc = pc; c.pc_plus1 = pp1;
        exp_q.push_back(c);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_instr"},  if_id_instr, 32'h0);
        chk({tag, "_pc"},     if_id_pc, 32'h0);
        chk({tag, "_pp1"},    if_id_pc_plus1, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_count"},  fetch_count, 32'h0);
        chk({tag, "_rd_en"},  {31'h0, imem_rd_en}, 32'h0);
        chk({tag, "_addr"},   imem_addr, 32'h0);
    endtask

    // Monitor: every new delivery (counter moves while out of reset) pops one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fetch_count !== last_count) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_capture", if_id_pc, 32'hFFFF_FFFF);
            end else begin
                cap_t e;
                e = exp_q.pop_front();
                chk("cap_instr", if_id_instr, e.instr);
                chk("cap_pc", if_id_pc, e.pc);
                chk("cap_pc_plus1", if_id_pc_plus1, e.pc_plus1);
                chk("cap_valid", {31'h0, if_id_valid}, 32'h1);
                chk("cap_count_step", fetch_count, last_count + 32'd1);
            end
        end
        last_count = fetch_count;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0100_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        mem[5] = 32'hFC00_0000;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        step(); step();
        chk_reset_outputs("reset");

        // Boot cycle, then three consecutive captures with a stall after 0x22
        rst_n = 1'b1;
        #1 chk("boot_rd_en", {31'h0, imem_rd_en}, 32'h0);
        step();
        chk("fetch_rd_en", {31'h0, imem_rd_en}, 32'h1);
        chk("fetch_addr0", imem_addr, 32'h0);
        push(32'h11, 32'h0, 32'h1);
        push(32'h22, 32'h1, 32'h2);
        step(); step();
        stall = 1'b1;
        #1 chk("stall_rd_en", {31'h0, imem_rd_en}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", if_id_instr, 32'h22);
            chk("stall_addr", imem_addr, 32'h2);
        end
        stall = 1'b0;
        push(32'h33, 32'h2, 32'h3);
        step();
        chk("count_after_3", fetch_count, 32'h3);

        // Redirect overrides stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
        chk("redir_instr", if_id_instr, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_count", fetch_count, 32'h3);
        stall = 1'b0; redirect = 1'b0;
        push(32'h0100_0040, 32'h40, 32'h41);
        step();
        chk("redir_if_id_pc", if_id_pc, 32'h40);
        chk("redir_next_addr", imem_addr, 32'h41);

        // Halt at address 5
        redirect = 1'b1; redirect_pc = 32'h3;
        step();
        redirect = 1'b0;
        push(32'h0100_0003, 32'h3, 32'h4);
        push(32'h0100_0004, 32'h4, 32'h5);
        push(32'hFC00_0000, 32'h5, 32'h6);
        step(); step(); step();
        chk("halt_valid", {31'h0, if_id_valid}, 32'h1);
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_rd_en", {31'h0, imem_rd_en}, 32'h0);
        step();
        chk("halt_invalid", {31'h0, if_id_valid}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_pc_hold", imem_addr, 32'h6);
            chk("halt_hold_flag", {31'h0, halted}, 32'h1);
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        chk("unhalt_flag", {31'h0, halted}, 32'h0);
        chk("unhalt_addr", imem_addr, 32'h0);
        redirect = 1'b0;
        push(32'h11, 32'h0, 32'h1);
        step();

        // Wrap at the top of the PC range
        redirect = 1'b1; redirect_pc = 32'hFFFF;
        step();
        redirect = 1'b0;
        push(32'h0100_FFFF, 32'hFFFF, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pp1", if_id_pc_plus1, 32'h0);
        push(32'h11, 32'h0, 32'h1);
        step();

        // Reset mid-run at pc=0x123
        redirect = 1'b1; redirect_pc = 32'h122;
        step();
        redirect = 1'b0;
        push(32'h0100_0122, 32'h122, 32'h123);
        step();
        chk("mid_valid", {31'h0, if_id_valid}, 32'h1);
        chk("mid_addr", imem_addr, 32'h123);
        @(negedge clk);
        #1 rst_n = 1'b0;
        step();
        chk_reset_outputs("midreset");
        chk("scoreboard_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
